// File: rtl/bufba_share_arb.sv
// Round-robin arbiter that lets NREQ requesters take turns driving a shared buffered broadcast line.
// Optional idle-grant timeout is enabled with `define BUFBA_SHARE_ARB_TIMEOUT_EN.
module bufba_share_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ-1:0]    VLD,
  input  logic [NREQ-1:0]    LAST,
  input  logic [NREQ*DW-1:0] DIN,
  output logic [NREQ-1:0]    GNT,
  output logic [DW-1:0]      Z,
  output logic               ZV,
  output logic               BUSY,
  output logic               TOUT
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("bufba_share_arb: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, ptr_nx;
  logic [NREQ-1:0] gnt_q, gnt_nx;
  logic [DW-1:0]   z_q, z_nx;
  logic            zv_q, zv_nx;
  logic            busy_q, busy_nx;

  logic            found;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   cand;
  logic            req_g, vld_g, last_g;
  logic [DW-1:0]   din_g;

`ifdef BUFBA_SHARE_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt, cnt_nx;
  logic            tout_q, tout_nx;
`endif

  // Rotating priority search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    cand  = ptr;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = PW'((int'(ptr) + k) % int'(NREQ));
      if (!found && REQ[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // The granted index is always the pointer while in GRANT.
  always_comb begin
    req_g  = 1'b0;
    vld_g  = 1'b0;
    last_g = 1'b0;
    din_g  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (ptr == PW'(i)) begin
        req_g  = REQ[i];
        vld_g  = VLD[i];
        last_g = LAST[i];
        din_g  = DIN[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gnt_nx   = gnt_q;
    z_nx     = z_q;
    zv_nx    = 1'b0;
`ifdef BUFBA_SHARE_ARB_TIMEOUT_EN
    cnt_nx   = '0;
    tout_nx  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          ptr_nx   = sel;
          gnt_nx   = NREQ'(1) << sel;
        end
      end
      GRANT: begin
        if (vld_g) begin
          z_nx  = din_g;
          zv_nx = 1'b1;
        end
`ifdef BUFBA_SHARE_ARB_TIMEOUT_EN
        cnt_nx = vld_g ? '0 : cnt + CW'(1);
`endif
        if ((vld_g && last_g) || !req_g) begin
          state_nx = GAP;
          gnt_nx   = '0;
        end
`ifdef BUFBA_SHARE_ARB_TIMEOUT_EN
        else if (!vld_g && (cnt == CW'(TIMEOUT - 1))) begin
          state_nx = GAP;
          gnt_nx   = '0;
          tout_nx  = 1'b1;
          cnt_nx   = '0;
        end
`endif
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      ptr    <= PW'(NREQ - 1);
      gnt_q  <= '0;
      z_q    <= '0;
      zv_q   <= 1'b0;
      busy_q <= 1'b0;
`ifdef BUFBA_SHARE_ARB_TIMEOUT_EN
      cnt    <= '0;
      tout_q <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      gnt_q  <= gnt_nx;
      z_q    <= z_nx;
      zv_q   <= zv_nx;
      busy_q <= busy_nx;
`ifdef BUFBA_SHARE_ARB_TIMEOUT_EN
      cnt    <= cnt_nx;
      tout_q <= tout_nx;
`endif
    end
  end

  assign GNT  = gnt_q;
  assign Z    = z_q;
  assign ZV   = zv_q;
  assign BUSY = busy_q;
`ifdef BUFBA_SHARE_ARB_TIMEOUT_EN
  assign TOUT = tout_q;
`else
  assign TOUT = 1'b0;
`endif

endmodule

// File: tb/tb_bufba_share_arb.sv
// Bench for bufba_share_arb: burst-level reference model checked every cycle, plus directed literal checks.
module tb_bufba_share_arb;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TMO  = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [3:0]      REQ = '0;
  logic [3:0]      VLD = '0;
  logic [3:0]      LAST = '0;
  logic [31:0]     DIN = '0;
  logic [3:0]      GNT;
  logic [7:0]      Z;
  logic            ZV, BUSY, TOUT;

  int n_cmp = 0;
  int n_bad = 0;
  bit run   = 0;

  bufba_share_arb #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .VLD(VLD), .LAST(LAST), .DIN(DIN),
    .GNT(GNT), .Z(Z), .ZV(ZV), .BUSY(BUSY), .TOUT(TOUT)
  );

  always #5 CLK = ~CLK;

  // Reference: who owns the line, whether we are in the post-burst gap, and the last winner.
  typedef struct {
    int         owner;
    bit         gap;
    int         last;
    logic [7:0] z;
    bit         zv;
    bit         tout;
    int         idle;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.owner = -1; m.gap = 0; m.last = NREQ - 1;
    m.z = '0; m.zv = 0; m.tout = 0; m.idle = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic [3:0] req, logic [3:0] vld,
                                        logic [3:0] last, logic [31:0] din);
    model_t n;
    int     g;
    bit     done;
    n = m;
    n.zv = 0;
    n.tout = 0;
    if (m.gap) begin
      n.gap = 0;
    end else if (m.owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m.last + k) % NREQ;
        if (req[c] && n.owner < 0) begin
          n.owner = c;
          n.last  = c;
          n.idle  = 0;
        end
      end
    end else begin
      g = m.owner;
      if (vld[g]) begin
        n.z    = 8'(din >> (g * 8));
        n.zv   = 1;
        n.idle = 0;
      end else begin
        n.idle = m.idle + 1;
      end
      done = (vld[g] && last[g]) || !req[g];
`ifdef BUFBA_SHARE_ARB_TIMEOUT_EN
      if (!done && n.idle >= TMO) begin
        done   = 1;
        n.tout = 1;
      end
`endif
      if (done) begin
        n.owner = -1;
        n.gap   = 1;
        n.idle  = 0;
      end
    end
    return n;
  endfunction

  model_t m = model_reset();

  always @(posedge CLK or posedge RST) begin
    if (RST) m <= model_reset();
    else     m <= model_step(m, REQ, VLD, LAST, DIN);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (run) begin
        check("model_gnt",  32'(GNT),  (m.owner >= 0) ? 32'(1 << m.owner) : 32'd0);
        check("model_z",    32'(Z),    32'(m.z));
        check("model_zv",   32'(ZV),   32'(m.zv));
        check("model_busy", 32'(BUSY), 32'(m.owner >= 0 || m.gap));
        check("model_tout", 32'(TOUT), 32'(m.tout));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  int ord[5];
  int n_ord;
  int gcyc, tcnt;
  logic [3:0] prev_gnt;
  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    #1 RST = 1'b1;
    #3;
    check("rst_gnt",  32'(GNT),  32'd0);
    check("rst_z",    32'(Z),    32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_tout", 32'(TOUT), 32'd0);
    tick();
    run = 1;
    tick();
    RST = 1'b0;

    // Single three-beat burst from requester 0.
    REQ = 4'b0001;
    tick();
    check("burst_gnt", 32'(GNT), 32'h1);
    VLD[0] = 1'b1; DIN[7:0] = 8'h11;
    tick();
    check("burst_z11", 32'(Z), 32'h11);
    check("burst_zv1", 32'(ZV), 32'h1);
    DIN[7:0] = 8'h22;
    tick();
    check("burst_z22", 32'(Z), 32'h22);
    DIN[7:0] = 8'h33; LAST[0] = 1'b1;
    tick();
    check("burst_z33",     32'(Z),    32'h33);
    check("burst_gnt_end", 32'(GNT),  32'h0);
    check("burst_busy_gap", 32'(BUSY), 32'h1);
    REQ = '0; VLD = '0; LAST = '0;
    tick();
    check("burst_busy_low", 32'(BUSY), 32'h0);

    // Round robin from reset with all requesters sending single-beat bursts.
    RST = 1'b1;
    tick();
    REQ = 4'b1111; VLD = 4'b1111; LAST = 4'b1111; DIN = 32'h44332211;
    RST = 1'b0;
    n_ord = 0;
    prev_gnt = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (GNT != 4'b0000 && prev_gnt == 4'b0000 && n_ord < 5) begin
        ord[n_ord] = onehot_idx(GNT);
        n_ord++;
      end
      prev_gnt = GNT;
    end
    check("rr_count", 32'(n_ord), 32'd5);
    for (int i = 0; i < 5; i++) check("rr_order", 32'(ord[i]), 32'(exp_ord[i]));
    REQ = '0; VLD = '0; LAST = '0;
    tick(); tick(); tick();

    // Pointer priority: win with requester 1, then 1010 must pick requester 3.
    pulse_reset();
    REQ = 4'b0010;
    tick();
    check("ptr_first", 32'(GNT), 32'h2);
    VLD[1] = 1'b1; LAST[1] = 1'b1; DIN[15:8] = 8'h77;
    tick();
    REQ = '0; VLD = '0; LAST = '0;
    tick();
    REQ = 4'b1010;
    tick();
    check("ptr_prio", 32'(GNT), 32'h8);
    VLD[3] = 1'b1; LAST[3] = 1'b1; DIN[31:24] = 8'h88;
    tick();
    REQ = '0; VLD = '0; LAST = '0;
    tick();

    // Abort by requester 2 with a final beat; requester 1 toggles noise.
    REQ = 4'b0100; DIN[15:8] = 8'hEE;
    tick();
    check("abort_gnt", 32'(GNT), 32'h4);
    VLD = 4'b0010;
    tick();
    check("noise_zv", 32'(ZV), 32'h0);
    VLD = 4'b0110; LAST = 4'b0010; DIN[23:16] = 8'h5A; REQ = 4'b0000;
    tick();
    check("abort_z",   32'(Z),   32'h5A);
    check("abort_zv",  32'(ZV),  32'h1);
    check("abort_gnt0", 32'(GNT), 32'h0);
    VLD = 4'b0000;
    tick();
    check("abort_zv_once", 32'(ZV), 32'h0);
    check("abort_z_hold",  32'(Z),  32'h5A);
    VLD = 4'b0010; LAST = '0;
    tick();
    VLD = '0;
    tick();

    // Reset in the middle of a four-beat burst from requester 3.
    REQ = 4'b1000;
    tick();
    check("mid_gnt", 32'(GNT), 32'h8);
    VLD[3] = 1'b1; DIN[31:24] = 8'hA1;
    tick();
    check("mid_beat1", 32'(Z), 32'hA1);
    DIN[31:24] = 8'hA2;
    RST = 1'b1;
    #1;
    check("mid_rst_gnt",  32'(GNT),  32'h0);
    check("mid_rst_z",    32'(Z),    32'h0);
    check("mid_rst_zv",   32'(ZV),   32'h0);
    check("mid_rst_busy", 32'(BUSY), 32'h0);
    REQ = 4'b1111; VLD = '0;
    tick();
    RST = 1'b0;
    tick();
    check("post_rst_gnt", 32'(GNT), 32'h1);
    REQ = '0;
    tick(); tick();

    // Granted requester never sends data.
    REQ = 4'b0001;
    tick();
    gcyc = 0; tcnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (GNT == 4'b0001) gcyc++;
      if (TOUT) begin
        tcnt++;
        check("tout_gnt_clear", 32'(GNT), 32'h0);
        REQ = '0;
      end
      tick();
    end
`ifdef BUFBA_SHARE_ARB_TIMEOUT_EN
    check("tout_gnt_cycles", 32'(gcyc), 32'd16);
    check("tout_pulses",     32'(tcnt), 32'd1);
`else
    check("hold_gnt_cycles", 32'(gcyc), 32'd100);
    check("hold_tout",       32'(tcnt), 32'd0);
    check("hold_gnt_end",    32'(GNT),  32'h1);
`endif
    REQ = '0;
    tick(); tick(); tick();

    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bufba_share_arb.md
BUFBA_SHARE_ARB -- requirements
Module: bufba_share_arb

Interface
- REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the buffered broadcast line; legal range 2..8.
- REQ-002 SHALL have parameter DW, default 8: broadcast data width.
- REQ-003 SHALL have parameter TIMEOUT, default 16: idle-grant cycle limit, used only with the macro in REQ-021.
- REQ-004 SHALL have port CLK, input, 1: the single clock; all logic is rising-edge.
- REQ-005 SHALL have port RST, input, 1: reset, asynchronous, active-high.
- REQ-006 SHALL have port REQ, input, NREQ: per-requester bus request.
- REQ-007 SHALL have port VLD, input, NREQ: per-requester data-valid.
- REQ-008 SHALL have port LAST, input, NREQ: per-requester final-beat marker, qualified by VLD.
- REQ-009 SHALL have port DIN, input, NREQ*DW: requester i's data occupies bits [i*DW +: DW].
- REQ-010 SHALL have port GNT, output, NREQ: one-hot grant, registered.
- REQ-011 SHALL have port Z, output, DW: registered broadcast data driven onto the shared BUFBA line.
- REQ-012 SHALL have port ZV, output, 1: Z-valid strobe.
- REQ-013 SHALL have port BUSY, output, 1: high when state is not IDLE.
- REQ-014 SHALL have port TOUT, output, 1: one-cycle timeout pulse.

Function
- REQ-015 SHALL implement states IDLE, GRANT and GAP.
- REQ-016 IDLE, any REQ high: select the first requester with REQ high, searching from ptr+1 modulo NREQ; next cycle enter GRANT, GNT equals one-hot of the selected index, ptr is loaded with that index; REQ-to-GNT latency is 1 cycle.
- REQ-017 GRANT, each cycle with VLD[g] high (g = granted index): Z loads DIN slice g and ZV=1 on the next cycle; otherwise ZV=0 next cycle and Z holds its value.
- REQ-018 GRANT exit to GAP, with GNT cleared on the next cycle, SHALL occur on:
  - VLD[g] and LAST[g] both high; or
  - REQ[g] low (abort); a beat with VLD[g] high in that same cycle is still transferred.
- REQ-019 GAP SHALL last exactly 1 cycle with GNT=0 and ZV=0, then enter IDLE; the minimum gap between bursts is 2 cycles.
- REQ-020 The block SHALL ignore REQ, VLD, LAST and DIN of non-granted requesters; REQ changes during GRANT or GAP SHALL have no effect until IDLE.

Reset
- REQ-023 While RST is high, the block SHALL force asynchronously:
  - state=IDLE, GNT=0, Z=0, ZV=0, BUSY=0, TOUT=0;
  - ptr=NREQ-1, so requester 0 wins first;
  - timeout counter=0.
- REQ-024 RST asserted mid-burst SHALL abandon the burst with no completion beat; after release, arbitration restarts per REQ-016.

Configuration
- REQ-021 With BUFBA_SHARE_ARB_TIMEOUT_EN defined:
  - a counter SHALL count consecutive GRANT cycles with VLD[g] low, clearing on any VLD[g];
  - when the count reaches TIMEOUT, the next state SHALL be GAP, with TOUT=1 for that one cycle and GNT cleared.
- REQ-022 Without BUFBA_SHARE_ARB_TIMEOUT_EN: no counter SHALL exist, TOUT SHALL be constant 0, and a grant SHALL be held indefinitely until REQ-018.

Verification
- REQ-025 Single burst: reset, then REQ=0001 with DIN0 beats 0x11, 0x22, 0x33 (LAST on 0x33) -> GNT=0001 after 1 cycle, Z/ZV show 0x11, 0x22, 0x33 on consecutive cycles, GNT=0 after LAST, BUSY low 2 cycles after LAST.
- REQ-026 Round robin: REQ=1111 held, each requester sends one beat with LAST -> grant order 0, 1, 2, 3, 0.
- REQ-027 Pointer priority: ptr=1, REQ=1010 asserted in IDLE -> GNT=1000.
- REQ-028 Abort and noise: granted requester 2 drops REQ with VLD=1 and DIN=0x5A -> Z=0x5A, ZV=1 once, then GAP; requester 1 VLD/DIN toggled meanwhile -> never appears on Z.
- REQ-029 Reset mid-burst: RST pulsed during beat 2 of a 4-beat burst from requester 3 -> GNT, Z, ZV, BUSY go 0 without waiting for a clock edge; with REQ=1111 afterwards, first grant is 0001.
- REQ-030 Timeout: macro defined, TIMEOUT=16, granted requester holds VLD=0 -> TOUT=1 for 1 cycle after 16 cycles, GNT=0 the next cycle; macro undefined -> GNT held for 100 cycles, TOUT=0 throughout.
